hazard_controller: RTL and testbench

//  ID-stage hazard sequencer for the 5-stage RV32 pipeline; companion to the EX-stage forwarding logic.

---
 rtl/hazard_controller_pkg.sv | 22 ++
 rtl/hazard_scoreboard.sv | 60 ++++++
 rtl/hazard_controller.sv | 116 +++++++++++
 tb/tb_hazard_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the ID-stage hazard sequencer.
package hazard_controller_pkg;

  localparam int          REG_AW   = 5;
  localparam int          NUM_REGS = 32;
  localparam int          CNT_W    = 3;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  // Debug classification of the winning hazard term (highest priority first).
  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_LOAD_USE,
    HZ_RAW_SB,
    HZ_WAW_SB,
    HZ_STRUCT
  } hz_cause_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Register scoreboard for outstanding long-latency writes plus in-flight op count.
module hazard_scoreboard
  import hazard_controller_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_i,
  input  logic [REG_AW-1:0]   set_rd_i,
  input  logic                wb_valid_i,
  input  logic [REG_AW-1:0]   wb_rd_i,
  output logic [NUM_REGS-1:0] sb_eff_o,
  output logic [CNT_W-1:0]    pending_o,
  output logic                full_o
);

  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REGS-1:0] wb_mask, set_mask;
  logic                dec;

  // Next-state for scoreboard and counter; a same-cycle writeback is already visible to readers.
  always_comb begin
    wb_mask  = wb_valid_i ? reg_onehot(wb_rd_i) : '0;
    set_mask = issue_i ? reg_onehot(set_rd_i) : '0;
    sb_eff_o = sb_q & ~wb_mask;
    // Set is applied after clear so a register re-issued in its writeback cycle stays busy.
    sb_d     = (sb_q & ~wb_mask) | set_mask;
    sb_d[0]  = 1'b0;
    // A writeback with nothing in flight is dropped rather than underflowing the count.
    dec      = wb_valid_i & (cnt_q != '0);
    cnt_d    = cnt_q;
    if (issue_i && !dec) cnt_d = cnt_q + 1'b1;
    else if (dec && !issue_i) cnt_d = cnt_q - 1'b1;
    // Capacity check sees the slot freed by a same-cycle writeback.
    full_o   = (cnt_q - CNT_W'(dec)) == CNT_W'(MAX_OUTSTANDING);
  end

  // Scoreboard and in-flight counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign pending_o = cnt_q;

`ifndef SYNTHESIS
  // A writeback with no outstanding op indicates a broken long-unit handshake.
  always @(posedge clk) begin
    if (rst_n) assert (!(wb_valid_i && cnt_q == '0));
  end
`endif

endmodule

// File: rtl/hazard_controller.sv
// ID-stage hazard sequencer: load-use, scoreboard RAW/WAW, long-unit structural stalls,
// redirect flush priority, stall watchdog and stall-cycle counter.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int WDOG_LIMIT      = 200,
  parameter int WDOG_W          = 8,
  parameter int PERF_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rs2_id,
  input  logic              rs1_used_id,
  input  logic              rs2_used_id,
  input  logic [4:0]        rd_id,
  input  logic              reg_write_id,
  input  logic              long_id,
  input  logic [4:0]        rd_ex,
  input  logic              mem_read_ex,
  input  logic              branch_taken_ex,
  input  logic              long_busy,
  input  logic              long_wb_valid,
  input  logic [4:0]        long_wb_rd,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_id,
  output logic              flush_ex,
  output logic [2:0]        pending_cnt,
  output logic              stall_timeout,
  output logic [PERF_W-1:0] stall_cycles
);

  logic [NUM_REGS-1:0] sb_eff;
  logic                full;
  logic                load_use, raw_sb, waw_sb, struct_hz, hz, issue;
  hz_cause_e           cause;
  logic [4:0]          set_rd;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                timeout_q, timeout_d;
  logic [PERF_W-1:0]   perf_q, perf_d;

  assign set_rd = reg_write_id ? rd_id : REG_ZERO;

  hazard_scoreboard #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_i   (issue),
    .set_rd_i  (set_rd),
    .wb_valid_i(long_wb_valid),
    .wb_rd_i   (long_wb_rd),
    .sb_eff_o  (sb_eff),
    .pending_o (pending_cnt),
    .full_o    (full)
  );

  // Hazard detection and cause classification.
  always_comb begin
    load_use  = mem_read_ex && (rd_ex != REG_ZERO) &&
                ((rs1_used_id && rd_ex == rs1_id) || (rs2_used_id && rd_ex == rs2_id));
    raw_sb    = (rs1_used_id && sb_eff[rs1_id]) || (rs2_used_id && sb_eff[rs2_id]);
    waw_sb    = reg_write_id && (rd_id != REG_ZERO) && sb_eff[rd_id];
    struct_hz = long_id && (long_busy || full);
    cause = HZ_NONE;
    if (load_use)       cause = HZ_LOAD_USE;
    else if (raw_sb)    cause = HZ_RAW_SB;
    else if (waw_sb)    cause = HZ_WAW_SB;
    else if (struct_hz) cause = HZ_STRUCT;
    hz    = (cause != HZ_NONE);
    issue = long_id && !hz && !branch_taken_ex;
  end

  // Stall/flush outputs; a redirect discards the ID instruction so it never stalls.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (branch_taken_ex) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (hz) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  // Watchdog (saturating, consecutive stalls) and wrapping stall-cycle counter next state.
  always_comb begin
    wdog_d = '0;
    if (stall_if) wdog_d = (wdog_q == WDOG_W'(WDOG_LIMIT)) ? wdog_q : wdog_q + 1'b1;
    timeout_d = timeout_q | (wdog_d == WDOG_W'(WDOG_LIMIT));
    perf_d    = stall_if ? perf_q + 1'b1 : perf_q;
  end

  // Watchdog, sticky timeout flag and perf counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      perf_q    <= '0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      perf_q    <= perf_d;
    end
  end

  assign stall_timeout = timeout_q;
  assign stall_cycles  = perf_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_id, rs2_id, rd_id, rd_ex, long_wb_rd;
  logic        rs1_used_id, rs2_used_id, reg_write_id, long_id;
  logic        mem_read_ex, branch_taken_ex, long_busy, long_wb_valid;
  logic        stall_if, stall_id, flush_id, flush_ex, stall_timeout;
  logic [2:0]  pending_cnt;
  logic [31:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_id         (rs1_id),
    .rs2_id         (rs2_id),
    .rs1_used_id    (rs1_used_id),
    .rs2_used_id    (rs2_used_id),
    .rd_id          (rd_id),
    .reg_write_id   (reg_write_id),
    .long_id        (long_id),
    .rd_ex          (rd_ex),
    .mem_read_ex    (mem_read_ex),
    .branch_taken_ex(branch_taken_ex),
    .long_busy      (long_busy),
    .long_wb_valid  (long_wb_valid),
    .long_wb_rd     (long_wb_rd),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .flush_id       (flush_id),
    .flush_ex       (flush_ex),
    .pending_cnt    (pending_cnt),
    .stall_timeout  (stall_timeout),
    .stall_cycles   (stall_cycles)
  );

  task automatic idle();
    rs1_id = 0; rs2_id = 0; rd_id = 0; rd_ex = 0; long_wb_rd = 0;
    rs1_used_id = 0; rs2_used_id = 0; reg_write_id = 0; long_id = 0;
    mem_read_ex = 0; branch_taken_ex = 0; long_busy = 0; long_wb_valid = 0;
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL rst_pending got %0d want 0", pending_cnt); end
    n_cmp++; if (stall_timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout got %0b want 0", stall_timeout); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL rst_cycles got %0d want 0", stall_cycles); end
    n_cmp++; if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000) begin n_err++;
      $display("FAIL rst_ctrl got %b want 0000", {stall_if, stall_id, flush_id, flush_ex}); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    // lw x5 in EX; add x6,x5,x1 in ID
    idle();
    mem_read_ex = 1; rd_ex = 5;
    rs1_id = 5; rs1_used_id = 1; rs2_id = 1; rs2_used_id = 1; rd_id = 6; reg_write_id = 1;
    settle();
    n_cmp++; if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b1101) begin n_err++;
      $display("FAIL lu_ctrl got %b want 1101", {stall_if, stall_id, flush_id, flush_ex}); end
    tick();
    // Bubble now in EX
    mem_read_ex = 0; rd_ex = 0;
    settle();
    n_cmp++; if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000) begin n_err++;
      $display("FAIL lu_release got %b want 0000", {stall_if, stall_id, flush_id, flush_ex}); end
    n_cmp++; if (stall_cycles !== 32'd1) begin n_err++; $display("FAIL lu_cycles got %0d want 1", stall_cycles); end
    // rs2 matches but is not read -> no hazard
    mem_read_ex = 1; rd_ex = 5; rs1_id = 1; rs2_id = 5; rs2_used_id = 0;
    settle();
    n_cmp++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL lu_unused_rs2 got %0b want 0", stall_if); end
    // rs2 read and matching -> hazard
    rs2_used_id = 1;
    settle();
    n_cmp++; if (stall_if !== 1'b1) begin n_err++; $display("FAIL lu_rs2 got %0b want 1", stall_if); end
    idle();
    tick();
  endtask

  task automatic test_mul_raw();
    // mul x7,x1,x2 issues
    idle();
    long_id = 1; reg_write_id = 1; rd_id = 7; rs1_id = 1; rs2_id = 2; rs1_used_id = 1; rs2_used_id = 1;
    settle();
    n_cmp++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL mul_issue_stall got %0b want 0", stall_if); end
    tick();
    n_cmp++; if (pending_cnt !== 3'd1) begin n_err++; $display("FAIL mul_pending got %0d want 1", pending_cnt); end
    // add x8,x7,x0 waits on x7
    idle();
    rs1_id = 7; rs1_used_id = 1; rd_id = 8; reg_write_id = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++; if ({stall_if, stall_id, flush_ex} !== 3'b111) begin n_err++;
        $display("FAIL raw_wait%0d got %b want 111", i, {stall_if, stall_id, flush_ex}); end
      tick();
    end
    // Writeback cycle releases the waiter
    long_wb_valid = 1; long_wb_rd = 7;
    settle();
    n_cmp++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL raw_wb_cycle got %0b want 0", stall_if); end
    tick();
    long_wb_valid = 0; long_wb_rd = 0;
    settle();
    n_cmp++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL raw_sb_cleared got %0b want 0", stall_if); end
    n_cmp++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL raw_pending got %0d want 0", pending_cnt); end
    n_cmp++; if (stall_cycles !== 32'd4) begin n_err++; $display("FAIL raw_cycles got %0d want 4", stall_cycles); end
    idle();
    tick();
  endtask

  task automatic test_struct();
    idle();
    long_id = 1; reg_write_id = 1; rd_id = 10;
    tick();
    rd_id = 11;
    tick();
    n_cmp++; if (pending_cnt !== 3'd2) begin n_err++; $display("FAIL st_pending2 got %0d want 2", pending_cnt); end
    // Third mul blocked by capacity
    rd_id = 12;
    settle();
    n_cmp++; if ({stall_if, flush_ex, flush_id} !== 3'b110) begin n_err++;
      $display("FAIL st_full got %b want 110", {stall_if, flush_ex, flush_id}); end
    tick();
    // Writeback of x10 frees a slot in the same cycle
    long_wb_valid = 1; long_wb_rd = 10;
    settle();
    n_cmp++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL st_wb_issue got %0b want 0", stall_if); end
    tick();
    n_cmp++; if (pending_cnt !== 3'd2) begin n_err++; $display("FAIL st_pending_hold got %0d want 2", pending_cnt); end
    // WAW: non-long op writing x11 while x11 is outstanding
    idle();
    reg_write_id = 1; rd_id = 11;
    settle();
    n_cmp++; if (stall_if !== 1'b1) begin n_err++; $display("FAIL st_waw got %0b want 1", stall_if); end
    // Writing x0 never causes WAW
    rd_id = 0;
    settle();
    n_cmp++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL st_waw_x0 got %0b want 0", stall_if); end
    idle();
    long_wb_valid = 1; long_wb_rd = 11;
    tick();
    long_wb_rd = 12;
    tick();
    idle();
    settle();
    n_cmp++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL st_drain got %0d want 0", pending_cnt); end
    n_cmp++; if (stall_cycles !== 32'd5) begin n_err++; $display("FAIL st_cycles got %0d want 5", stall_cycles); end
  endtask

  task automatic test_redirect();
    // Load-use plus a mul in ID, but EX redirects
    idle();
    mem_read_ex = 1; rd_ex = 5; rs1_id = 5; rs1_used_id = 1;
    long_id = 1; reg_write_id = 1; rd_id = 9; branch_taken_ex = 1;
    settle();
    n_cmp++; if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0011) begin n_err++;
      $display("FAIL br_ctrl got %b want 0011", {stall_if, stall_id, flush_id, flush_ex}); end
    tick();
    idle();
    rs1_id = 9; rs1_used_id = 1;
    settle();
    n_cmp++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL br_sb_untouched got %0b want 0", stall_if); end
    n_cmp++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL br_pending got %0d want 0", pending_cnt); end
    n_cmp++; if (stall_cycles !== 32'd5) begin n_err++; $display("FAIL br_cycles got %0d want 5", stall_cycles); end
    idle();
    tick();
  endtask

  task automatic test_watchdog();
    apply_reset();
    long_id = 1; long_busy = 1; reg_write_id = 1; rd_id = 3;
    for (int i = 0; i < 200; i++) begin
      if (i == 199) begin
        n_cmp++; if (stall_timeout !== 1'b0) begin n_err++; $display("FAIL wd_early got %0b want 0", stall_timeout); end
      end
      tick();
    end
    n_cmp++; if (stall_timeout !== 1'b1) begin n_err++; $display("FAIL wd_fire got %0b want 1", stall_timeout); end
    n_cmp++; if (stall_cycles !== 32'd200) begin n_err++; $display("FAIL wd_cycles got %0d want 200", stall_cycles); end
    idle();
    tick();
    tick();
    n_cmp++; if (stall_timeout !== 1'b1) begin n_err++; $display("FAIL wd_sticky got %0b want 1", stall_timeout); end
    n_cmp++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL wd_release got %0b want 0", stall_if); end
    n_cmp++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL wd_no_issue got %0d want 0", pending_cnt); end
  endtask

  task automatic test_async_reset();
    idle();
    long_id = 1; reg_write_id = 1; rd_id = 7;
    tick();
    idle();
    rs1_id = 7; rs1_used_id = 1;
    settle();
    n_cmp++; if (stall_if !== 1'b1) begin n_err++; $display("FAIL ar_pre_stall got %0b want 1", stall_if); end
    // Reset mid-cycle, no clock edge involved
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL ar_sb_clear got %0b want 0", stall_if); end
    n_cmp++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL ar_pending got %0d want 0", pending_cnt); end
    n_cmp++; if (stall_timeout !== 1'b0) begin n_err++; $display("FAIL ar_timeout got %0b want 0", stall_timeout); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL ar_cycles got %0d want 0", stall_cycles); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    // Load to x0 and consumer of x0: never a hazard
    idle();
    mem_read_ex = 1; rd_ex = 0; rs1_id = 0; rs1_used_id = 1;
    settle();
    n_cmp++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL ar_x0_load got %0b want 0", stall_if); end
    idle();
    tick();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_mul_raw();
    test_struct();
    test_redirect();
    test_watchdog();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
